// File: rtl/seq_log_pkg.sv
// seq_log_pkg: shared defaults, timestamp type and saturating-increment helper for seq_hit_logger.
package seq_log_pkg;
  localparam int DEF_TS_W = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_DROP_W = 8;
  localparam int DEF_IRQ_LVL = 4;
  typedef logic [DEF_TS_W-1:0] ts_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] m;
    m = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
    return (v >= m) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/seq_hit_logger_if.sv
// seq_hit_logger_if: valid/ready event stream carrying hit timestamps to the reader.
interface seq_hit_logger_if #(parameter int TS_W = 16) ();
  logic evt_vld;
  logic evt_rdy;
  logic [TS_W-1:0] evt_ts;
  modport master (output evt_vld, output evt_ts, input evt_rdy);
  modport slave (input evt_vld, input evt_ts, output evt_rdy);
endinterface

// File: rtl/seq_log_fifo.sv
// seq_log_fifo: first-word fall-through sync FIFO with wrap-bit pointers and sync flush.
module seq_log_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign level = wp - rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Masked while empty so the head reads zero after reset/flush.
  assign dout = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/seq_hit_logger.sv
// seq_hit_logger: timestamps detector hits into an event FIFO with saturating hit/drop counts; SEQ_LOG_IRQ_EN adds a level irq.
module seq_hit_logger import seq_log_pkg::*; #(
  parameter int TS_W = DEF_TS_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DROP_W = DEF_DROP_W,
  parameter int IRQ_LVL = DEF_IRQ_LVL
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hit,
  seq_hit_logger_if.master evt,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [DROP_W-1:0] drop_cnt
`ifdef SEQ_LOG_IRQ_EN
  ,output logic irq
`endif
);
  localparam int LW = $clog2(DEPTH) + 1;
  logic [TS_W-1:0] ts_cnt, head;
  logic full, empty, pop, push, drop;
  logic [31:0] hit_inc, drop_inc;
  assign pop = ~empty & evt.evt_rdy;
  // A full FIFO still takes the hit when the reader frees a slot this cycle.
  assign push = hit & ~clr & (~full | pop);
  assign drop = hit & ~clr & ~push;
  assign hit_inc = sat_inc(32'(hit_cnt), CNT_W);
  assign drop_inc = sat_inc(32'(drop_cnt), DROP_W);
  assign evt.evt_vld = ~empty;
  assign evt.evt_ts = head;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ts_cnt <= '0;
      hit_cnt <= '0;
      drop_cnt <= '0;
    end else if (clr) begin
      ts_cnt <= '0;
      hit_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if (hit) hit_cnt <= hit_inc[CNT_W-1:0];
      if (drop) drop_cnt <= drop_inc[DROP_W-1:0];
    end
  seq_log_fifo #(.W(TS_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(clr),
    .push(push),
    .pop(pop),
    .din(ts_cnt),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(level)
  );
`ifdef SEQ_LOG_IRQ_EN
  localparam logic [LW-1:0] IRQ_THR = LW'(IRQ_LVL);
  always_ff @(posedge clk or negedge rst)
    if (!rst) irq <= 1'b0;
    else irq <= ~clr & (level >= IRQ_THR);
`endif
endmodule

// File: tb/tb_seq_hit_logger.sv
// tb_seq_hit_logger: scoreboard bench for seq_hit_logger; build with SEQ_LOG_IRQ_EN to also cover irq.
module tb_seq_hit_logger;
  import seq_log_pkg::*;
  localparam int DEPTH = DEF_DEPTH;
  localparam int LW = $clog2(DEPTH) + 1;
  logic clk = 1'b0, rst = 1'b0, clr = 1'b0, hit = 1'b0;
  logic [LW-1:0] level;
  logic [DEF_CNT_W-1:0] hit_cnt;
  logic [DEF_DROP_W-1:0] drop_cnt;
`ifdef SEQ_LOG_IRQ_EN
  logic irq;
`endif
  seq_hit_logger_if #(.TS_W(DEF_TS_W)) evt ();
  seq_hit_logger dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .hit(hit),
    .evt(evt.master),
    .level(level),
    .hit_cnt(hit_cnt),
    .drop_cnt(drop_cnt)
`ifdef SEQ_LOG_IRQ_EN
    ,.irq(irq)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  ts_t exp_q[$];
  ts_t ts_m;
  logic [DEF_CNT_W-1:0] hit_m;
  logic [DEF_DROP_W-1:0] drop_m;

  // One cycle of stimulus from a negedge; the scoreboard is updated as stimulus is driven.
  task automatic cyc(input logic h, input logic r, input logic c);
    logic p;
    hit = h;
    evt.evt_rdy = r;
    clr = c;
    if (c) begin
      exp_q.delete();
      hit_m = '0;
      drop_m = '0;
      ts_m = '0;
    end else begin
      p = (exp_q.size() > 0) && r;
      if (h) begin
        if (hit_m != '1) hit_m++;
        if (exp_q.size() < DEPTH || p) exp_q.push_back(ts_m);
        else if (drop_m != '1) drop_m++;
      end
      if (p) void'(exp_q.pop_front());
      ts_m++;
    end
    @(negedge clk);
    hit = 1'b0;
    evt.evt_rdy = 1'b0;
    clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    hit = 1'b0;
    clr = 1'b0;
    evt.evt_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    ts_m = '0;
    hit_m = '0;
    drop_m = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    evt.evt_rdy = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({evt.evt_vld, evt.evt_ts, level, hit_cnt, drop_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got vld=%b ts=%0d lvl=%0d hit=%0d drop=%0d want all 0", evt.evt_vld, evt.evt_ts, level, hit_cnt, drop_cnt);
    end
`ifdef SEQ_LOG_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got=%b want=0", irq);
    end
`endif
  endtask

  task automatic test_two_hits();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (exp_q.size() > 0 ? (evt.evt_vld !== 1'b1 || evt.evt_ts !== exp_q[0]) : (evt.evt_vld !== 1'b0)) begin
        failures++;
        $display("FAIL two_hits_stream cyc=%0d got vld=%b ts=%0d want q=%0d", i, evt.evt_vld, evt.evt_ts, exp_q.size());
      end
      if (i == 6 || i == 10) begin
        checks++;
        if (evt.evt_vld !== 1'b1 || evt.evt_ts !== 16'(i - 1)) begin
          failures++;
          $display("FAIL two_hits_ts cyc=%0d got vld=%b ts=%0d want ts=%0d", i, evt.evt_vld, evt.evt_ts, i - 1);
        end
      end
      cyc(i == 5 || i == 9, 1'b1, 1'b0);
    end
    checks++;
    if (hit_cnt !== 16'd2 || drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL two_hits_cnt got hit=%0d drop=%0d want hit=2 drop=0", hit_cnt, drop_cnt);
    end
  endtask

  task automatic test_consecutive();
    do_reset();
    repeat (20) cyc(1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    checks++;
    if (level !== 4'd3) begin
      failures++;
      $display("FAIL consec_level got=%0d want=3", level);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (evt.evt_vld !== 1'b1 || evt.evt_ts !== exp_q[0] || evt.evt_ts !== 16'(20 + k)) begin
        failures++;
        $display("FAIL consec_order k=%0d got vld=%b ts=%0d want ts=%0d", k, evt.evt_vld, evt.evt_ts, 20 + k);
      end
      cyc(1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (evt.evt_vld !== 1'b0 || level !== 4'd0) begin
      failures++;
      $display("FAIL consec_empty got vld=%b lvl=%0d want 0 0", evt.evt_vld, level);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    repeat (10) cyc(1'b1, 1'b0, 1'b0);
    checks++;
    if (level !== 4'd8 || drop_cnt !== 8'd2 || hit_cnt !== 16'd10 || drop_cnt !== drop_m) begin
      failures++;
      $display("FAIL overflow_cnt got lvl=%0d drop=%0d hit=%0d want 8 2 10", level, drop_cnt, hit_cnt);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (evt.evt_vld !== 1'b1 || evt.evt_ts !== exp_q[0] || evt.evt_ts !== 16'(k)) begin
        failures++;
        $display("FAIL overflow_drain k=%0d got vld=%b ts=%0d want ts=%0d", k, evt.evt_vld, evt.evt_ts, k);
      end
      cyc(1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (evt.evt_vld !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL overflow_empty got vld=%b q=%0d want 0 0", evt.evt_vld, exp_q.size());
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    repeat (8) cyc(1'b1, 1'b0, 1'b0);
    checks++;
    if (level !== 4'd8 || evt.evt_ts !== 16'd0) begin
      failures++;
      $display("FAIL full_pre got lvl=%0d ts=%0d want 8 0", level, evt.evt_ts);
    end
    cyc(1'b1, 1'b1, 1'b0);
    checks++;
    if (level !== 4'd8 || drop_cnt !== 8'd0 || hit_cnt !== 16'd9) begin
      failures++;
      $display("FAIL full_pushpop got lvl=%0d drop=%0d hit=%0d want 8 0 9", level, drop_cnt, hit_cnt);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (evt.evt_vld !== 1'b1 || evt.evt_ts !== exp_q[0] || evt.evt_ts !== 16'(k + 1)) begin
        failures++;
        $display("FAIL full_drain k=%0d got vld=%b ts=%0d want ts=%0d", k, evt.evt_vld, evt.evt_ts, k + 1);
      end
      cyc(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_clr();
    do_reset();
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    checks++;
    if (level !== 4'd3) begin
      failures++;
      $display("FAIL clr_pre got lvl=%0d want=3", level);
    end
    cyc(1'b1, 1'b1, 1'b1);
    checks++;
    if (evt.evt_vld !== 1'b0 || level !== 4'd0 || hit_cnt !== 16'd0 || drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL clr_flush got vld=%b lvl=%0d hit=%0d drop=%0d want all 0", evt.evt_vld, level, hit_cnt, drop_cnt);
    end
    cyc(1'b1, 1'b0, 1'b0);
    checks++;
    if (evt.evt_vld !== 1'b1 || evt.evt_ts !== exp_q[0] || evt.evt_ts !== 16'd0 || hit_cnt !== 16'd1) begin
      failures++;
      $display("FAIL clr_restart got vld=%b ts=%0d hit=%0d want 1 0 1", evt.evt_vld, evt.evt_ts, hit_cnt);
    end
  endtask

  task automatic test_drop_sat();
    do_reset();
    repeat (268) cyc(1'b1, 1'b0, 1'b0);
    checks++;
    if (drop_cnt !== 8'hFF || drop_cnt !== drop_m || hit_cnt !== 16'd268 || level !== 4'd8) begin
      failures++;
      $display("FAIL drop_sat got drop=%0d hit=%0d lvl=%0d want 255 268 8", drop_cnt, hit_cnt, level);
    end
  endtask

`ifdef SEQ_LOG_IRQ_EN
  task automatic test_irq();
    do_reset();
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_below got=%b want=0", irq);
    end
    cyc(1'b1, 1'b0, 1'b0);
    checks++;
    if (level !== 4'd4 || irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_lag got lvl=%0d irq=%b want 4 0", level, irq);
    end
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_rise got=%b want=1", irq);
    end
    cyc(1'b0, 1'b1, 1'b0);
    checks++;
    if (level !== 4'd3 || irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_hold got lvl=%0d irq=%b want 3 1", level, irq);
    end
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_fall got=%b want=0", irq);
    end
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    checks++;
    if (level !== 4'd5 || hit_cnt !== 16'd5) begin
      failures++;
      $display("FAIL async_pre got lvl=%0d hit=%0d want 5 5", level, hit_cnt);
    end
    hit = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({evt.evt_vld, evt.evt_ts, level, hit_cnt, drop_cnt} !== '0) begin
      failures++;
      $display("FAIL async_reset got vld=%b ts=%0d lvl=%0d hit=%0d drop=%0d want all 0", evt.evt_vld, evt.evt_ts, level, hit_cnt, drop_cnt);
    end
`ifdef SEQ_LOG_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL async_irq got=%b want=0", irq);
    end
`endif
    hit = 1'b0;
    do_reset();
  endtask

  initial begin
    evt.evt_rdy = 1'b0;
    test_reset();
    test_two_hits();
    test_consecutive();
    test_overflow();
    test_full_push_pop();
    test_clr();
    test_drop_sat();
`ifdef SEQ_LOG_IRQ_EN
    test_irq();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
